// File: rtl/audio_pkg.sv
// Shared definitions for the audio level path: indicator direction codes and
// the window-trend FSM state type.
package audio_pkg;

    // Direction codes as understood by the up/down indicator.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // FIRST fills the very first window, PRIME stores it as the reference,
    // ACCUM fills later windows, COMPARE evaluates a window against the last one.
    typedef enum logic [1:0] {
        FIRST   = 2'd0,
        PRIME   = 2'd1,
        ACCUM   = 2'd2,
        COMPARE = 2'd3
    } trend_state_t;

endpackage

// File: rtl/window_accumulator.sv
// Sums saturated sample magnitudes over one window of 2**WIN_LOG2 accepted
// samples and flags the transfer that completes the window.
module window_accumulator
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = 12,
    parameter int WIN_LOG2 = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          xfer,
    input  logic                          clr,
    input  logic signed [SAMPLE_W-1:0]    sample,
    output logic [SAMPLE_W-2+WIN_LOG2:0]  acc,
    output logic                          last
);

    localparam int AW = SAMPLE_W - 1 + WIN_LOG2;
    localparam int MW = SAMPLE_W - 1;
    localparam logic [WIN_LOG2-1:0] CNT_MAX = {WIN_LOG2{1'b1}};
    localparam logic signed [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic [WIN_LOG2-1:0] cnt;
    logic [MW-1:0]       mag;

    // The most negative code has no positive counterpart, so it is clipped to
    // the largest positive magnitude to keep the magnitude one bit narrower.
    function automatic logic [MW-1:0] sat_abs(input logic signed [SAMPLE_W-1:0] s);
        logic signed [SAMPLE_W-1:0] neg;
        neg = -s;
        if (s == S_MIN)
            return {MW{1'b1}};
        else if (s[SAMPLE_W-1])
            return neg[MW-1:0];
        else
            return s[MW-1:0];
    endfunction

    assign mag  = sat_abs(sample);
    assign last = xfer && (cnt == CNT_MAX);

    // Window sum and sample count; count parks at its max after the final
    // sample and returns to zero when the window is evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (xfer) begin
            acc <= acc + {{WIN_LOG2{1'b0}}, mag};
            if (!last)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/level_trend_detector.sv
// Compares consecutive window magnitude sums and drives the up/down indicator,
// holding an indication for a few steady windows to avoid flicker.
module level_trend_detector
    import audio_pkg::*;
#(
    parameter int SAMPLE_W     = 12,
    parameter int WIN_LOG2     = 8,
    parameter int HYST         = 64,
    parameter int HOLD_WINDOWS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sample_valid,
    input  logic signed [SAMPLE_W-1:0]    sample,
    output logic                          sample_ready,
    output logic                          disp_en,
    output logic                          disp_dir,
    output logic                          win_done,
    output logic [SAMPLE_W-2+WIN_LOG2:0]  level
);

    localparam int AW = SAMPLE_W - 1 + WIN_LOG2;
    localparam int CW = AW + 2;
    localparam int HW = $clog2(HOLD_WINDOWS + 1);
    localparam logic [CW-1:0] HYST_X    = CW'(HYST);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_WINDOWS);

    trend_state_t state, state_nxt;

    logic          xfer;
    logic          win_last;
    logic          eval_prime;
    logic          eval_cmp;
    logic          acc_clr;
    logic [AW-1:0] acc;
    logic [AW-1:0] prev_sum;
    logic [HW-1:0] hold;
    logic [CW-1:0] cur_x;
    logic [CW-1:0] prev_x;
    logic          trend_up;
    logic          trend_down;

    assign xfer    = sample_valid && sample_ready;
    assign acc_clr = eval_prime | eval_cmp;

    window_accumulator #(
        .SAMPLE_W (SAMPLE_W),
        .WIN_LOG2 (WIN_LOG2)
    ) u_win_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .xfer   (xfer),
        .clr    (acc_clr),
        .sample (sample),
        .acc    (acc),
        .last   (win_last)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= FIRST;
        else
            state <= state_nxt;
    end

    // Next state: one evaluation cycle after every completed window.
    always_comb begin
        state_nxt = state;
        case (state)
            FIRST:   if (win_last) state_nxt = PRIME;
            PRIME:   state_nxt = ACCUM;
            ACCUM:   if (win_last) state_nxt = COMPARE;
            COMPARE: state_nxt = ACCUM;
            default: state_nxt = FIRST;
        endcase
    end

    // FSM outputs: input is stalled while a window is being evaluated.
    always_comb begin
        sample_ready = 1'b0;
        eval_prime   = 1'b0;
        eval_cmp     = 1'b0;
        case (state)
            FIRST, ACCUM: sample_ready = 1'b1;
            PRIME:        eval_prime   = 1'b1;
            COMPARE:      eval_cmp     = 1'b1;
            default:      sample_ready = 1'b0;
        endcase
    end

    // Extra headroom so adding the hysteresis can never wrap.
    assign cur_x      = CW'(acc);
    assign prev_x     = CW'(prev_sum);
    assign trend_up   = cur_x >= (prev_x + HYST_X);
    assign trend_down = (cur_x + HYST_X) <= prev_x;

    // Reference sum, debug level, indicator and hold counter, updated on each
    // evaluation; a steady window only counts down an active hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_sum <= '0;
            level    <= '0;
            win_done <= 1'b0;
            disp_en  <= 1'b0;
            disp_dir <= DIR_UP;
            hold     <= '0;
        end else begin
            win_done <= acc_clr;
            if (acc_clr) begin
                prev_sum <= acc;
                level    <= acc;
            end
            if (eval_cmp) begin
                if (trend_up) begin
                    disp_dir <= DIR_UP;
                    disp_en  <= 1'b1;
                    hold     <= HOLD_INIT;
                end else if (trend_down) begin
                    disp_dir <= DIR_DOWN;
                    disp_en  <= 1'b1;
                    hold     <= HOLD_INIT;
                end else if (hold != '0) begin
                    hold <= hold - 1'b1;
                    if (hold == HW'(1))
                        disp_en <= 1'b0;
                end
            end
        end
    end

endmodule
